// File: rtl/issue_sched_pkg.sv
// Shared constants for the issue scheduler: entry field offsets, default widths
// and the operand-need decode used by the readiness check.
package issue_sched_pkg;

  localparam int ISSUE_ENTRY_SIZE = 192;
  localparam int REG_SIZE         = 64;
  localparam int REG_IDX_W        = 6;

  localparam int DEST_LSB   = 174;
  localparam int SRCB_LSB   = 168;
  localparam int SRCA_LSB   = 161;
  localparam int DO_WB_BIT  = 140;
  localparam int LINK_BIT   = 139;
  localparam int ALUSRC_BIT = 132;
  localparam int SYSCAL_BIT = 128;

  // Linked and syscall ops carry no register sources; ALUSrc replaces srcB by an immediate.
  function automatic logic need_a(input logic link, input logic syscal);
    return !(link | syscal);
  endfunction

  function automatic logic need_b(input logic alusrc, input logic link, input logic syscal);
    return !(alusrc | link | syscal);
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Issue-queue side handshake and register-read side request of the scheduler.
interface issue_scheduler_if #(
  parameter int ISSUE_ENTRY_SIZE = issue_sched_pkg::ISSUE_ENTRY_SIZE
);
  logic                        in_valid;
  logic [ISSUE_ENTRY_SIZE-1:0] in_entry;
  logic                        in_ready;
  logic                        out_valid;
  logic [ISSUE_ENTRY_SIZE-1:0] out_entry;

  modport master (output in_valid, in_entry, input in_ready, out_valid, out_entry);
  modport slave  (input in_valid, in_entry, output in_ready, out_valid, out_entry);
endinterface

// File: rtl/oldest_pick.sv
// Finds the first set ready bit at or after head, wrapping around the window.
module oldest_pick #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         ready_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  output logic                     found_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] slot;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found_o = 1'b0;
    idx_o   = head_i;
    slot    = head_i;
    // Walk from the youngest offset down so the offset closest to head wins last.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      slot = head_i + IDX_W'(i);
      if (ready_i[slot]) begin
        found_o = 1'b1;
        idx_o   = slot;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Age-ordered issue window with a physical-register busy scoreboard; issues the
// oldest operand-ready entry each cycle as a registered request to register read.
module issue_scheduler #(
  parameter int ISSUE_ENTRY_SIZE = issue_sched_pkg::ISSUE_ENTRY_SIZE,
  parameter int DEPTH            = 8,
  parameter int REG_SIZE         = issue_sched_pkg::REG_SIZE
) (
  input  logic                     CLK,
  input  logic                     RESET,
  issue_scheduler_if.slave         io,
  input  logic                     FREEZE,
  input  logic                     wb_valid,
  input  logic [5:0]               wb_reg,
  input  logic                     mispredict,
  input  logic                     flush_fCOM,
  output logic [$clog2(DEPTH):0]   occupancy
);
  import issue_sched_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [ISSUE_ENTRY_SIZE-1:0] slot_q [DEPTH];
  logic [IDX_W-1:0]            head_q, head_d, tail_q, tail_d;
  logic [REG_SIZE-1:0]         busy_q, busy_d;
  logic                        out_valid_q, out_valid_d;
  logic [ISSUE_ENTRY_SIZE-1:0] out_entry_q, out_entry_d;

  logic [DEPTH-1:0] ready;
  logic             flush, enq, pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [REG_IDX_W-1:0] enq_dest;

  assign flush    = mispredict | flush_fCOM;
  assign enq      = io.in_valid & io.in_ready & ~flush;
  assign enq_dest = io.in_entry[DEST_LSB +: REG_IDX_W];

  // Register 0 never gets its busy bit set, so it always reads as ready.
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i]
        & ~(need_a(slot_q[i][LINK_BIT], slot_q[i][SYSCAL_BIT])
            & busy_q[slot_q[i][SRCA_LSB +: REG_IDX_W]])
        & ~(need_b(slot_q[i][ALUSRC_BIT], slot_q[i][LINK_BIT], slot_q[i][SYSCAL_BIT])
            & busy_q[slot_q[i][SRCB_LSB +: REG_IDX_W]]);
    end
  end

  oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .ready_i (ready),
    .head_i  (head_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    valid_d     = valid_q;
    busy_d      = busy_q;
    head_d      = head_q;
    tail_d      = tail_q;
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (flush) begin
      valid_d     = '0;
      busy_d      = '0;
      head_d      = '0;
      tail_d      = '0;
      out_valid_d = 1'b0;
      out_entry_d = '0;
    end else begin
      if (!FREEZE) begin
        out_valid_d = pick_found;
        out_entry_d = pick_found ? slot_q[pick_idx] : '0;
        if (pick_found) valid_d[pick_idx] = 1'b0;
      end
      if (wb_valid && wb_reg != '0) busy_d[wb_reg] = 1'b0;
      // A same-cycle enqueue of the same destination re-marks it busy.
      if (enq) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + IDX_W'(1);
        if (io.in_entry[DO_WB_BIT] && enq_dest != '0) busy_d[enq_dest] = 1'b1;
      end
      if (head_q != tail_q && !valid_d[head_q]) head_d = head_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q     <= '0;
      busy_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  // NOTE: slot payloads are not reset; valid_q gates every use of them.
  always_ff @(posedge CLK) begin
    if (enq) slot_q[tail_q] <= io.in_entry;
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(valid_q[i]);
  end

  assign io.in_ready  = ~valid_q[tail_q];
  assign io.out_valid = out_valid_q;
  assign io.out_entry = out_entry_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: a ring-window reference model checked every
// cycle, plus literal expectations on the scenarios of interest.
module tb_issue_scheduler;
  localparam int W = 192;
  localparam int D = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FREEZE, wb_valid, mispredict, flush_fCOM;
  logic [5:0] wb_reg;
  logic [3:0] occupancy;

  issue_scheduler_if #(.ISSUE_ENTRY_SIZE(W)) io ();

  issue_scheduler #(.ISSUE_ENTRY_SIZE(W), .DEPTH(D), .REG_SIZE(64)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .io         (io),
    .FREEZE     (FREEZE),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .mispredict (mispredict),
    .flush_fCOM (flush_fCOM),
    .occupancy  (occupancy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: ring of D slots, head/tail as plain integers, busy as a bit array.
  bit [W-1:0] m_slot [D];
  bit         m_valid[D];
  bit         m_busy [64];
  int         m_head, m_tail;
  bit         m_out_valid;
  bit [W-1:0] m_out_entry;
  bit         m_live = 1'b0;

  function automatic bit m_ready(input int s);
    bit [W-1:0] e;
    bit na, nb;
    e  = m_slot[s];
    na = !(e[139] | e[128]);
    nb = !(e[132] | e[139] | e[128]);
    return m_valid[s] && !(na && m_busy[e[166:161]]) && !(nb && m_busy[e[173:168]]);
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  always @(posedge CLK) begin : model
    int pick, t0;
    bit [W-1:0] e;
    if (RESET || mispredict || flush_fCOM) begin
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      for (int r = 0; r < 64; r++) m_busy[r] = 1'b0;
      m_head = 0;
      m_tail = 0;
      m_out_valid = 1'b0;
      m_out_entry = '0;
    end else begin
      t0 = m_tail;
      e  = io.in_entry;
      if (!FREEZE) begin
        pick = -1;
        for (int i = 0; i < D; i++)
          if (pick < 0 && m_ready((m_head + i) % D)) pick = (m_head + i) % D;
        if (pick >= 0) begin
          m_out_valid   = 1'b1;
          m_out_entry   = m_slot[pick];
          m_valid[pick] = 1'b0;
        end else begin
          m_out_valid = 1'b0;
          m_out_entry = '0;
        end
      end
      if (wb_valid && wb_reg != 0) m_busy[wb_reg] = 1'b0;
      if (io.in_valid && !m_valid[t0]) begin
        m_slot[t0]  = e;
        m_valid[t0] = 1'b1;
        if (e[140] && e[179:174] != 0) m_busy[e[179:174]] = 1'b1;
        m_tail = (t0 + 1) % D;
      end
      if (m_head != t0 && !m_valid[m_head]) m_head = (m_head + 1) % D;
    end
    m_live = 1'b1;
  end

  always @(negedge CLK) begin
    if (m_live) begin
      check("cyc_out_valid", W'(io.out_valid), W'(m_out_valid));
      check("cyc_out_entry", io.out_entry, m_out_entry);
      check("cyc_in_ready", W'(io.in_ready), W'(!m_valid[m_tail]));
      check("cyc_occupancy", W'(occupancy), W'(m_occ()));
    end
  end

  function automatic logic [W-1:0] mk(input int dest, input int sa, input int sb, input bit dowb,
                                      input int tag, input bit link = 1'b0,
                                      input bit alusrc = 1'b0, input bit syscal = 1'b0);
    logic [W-1:0] e;
    e          = '0;
    e[179:174] = dest[5:0];
    e[173:168] = sb[5:0];
    e[166:161] = sa[5:0];
    e[140]     = dowb;
    e[139]     = link;
    e[132]     = alusrc;
    e[128]     = syscal;
    e[31:0]    = tag;
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush_cycle();
    flush_fCOM = 1'b1;
    tick();
    flush_fCOM = 1'b0;
  endtask

  logic [W-1:0] e1, p, c, x, o, y, a, b, cc, lk;
  logic [W-1:0] blk [8];

  initial begin
    RESET = 1'b1; FREEZE = 1'b0; wb_valid = 1'b0; wb_reg = '0;
    mispredict = 1'b0; flush_fCOM = 1'b0;
    io.in_valid = 1'b0; io.in_entry = '0;
    tick(); tick();
    RESET = 1'b0;
    check("rst_out_valid", W'(io.out_valid), '0);
    check("rst_out_entry", io.out_entry, '0);
    check("rst_occupancy", W'(occupancy), '0);
    check("rst_in_ready", W'(io.in_ready), W'(1));

    // Independent entry issues one cycle after it is written.
    e1 = mk(5, 3, 4, 1'b1, 'h11);
    io.in_valid = 1'b1; io.in_entry = e1;
    tick();
    io.in_valid = 1'b0;
    check("t1_not_yet", W'(io.out_valid), '0);
    tick();
    check("t1_valid", W'(io.out_valid), W'(1));
    check("t1_entry", io.out_entry, e1);
    tick();
    check("t1_idle", W'(io.out_valid), '0);
    flush_cycle();

    // Producer/consumer with wakeup.
    p = mk(10, 1, 2, 1'b1, 'h21);
    c = mk(11, 10, 0, 1'b1, 'h22);
    io.in_valid = 1'b1; io.in_entry = p;
    tick();
    io.in_entry = c;
    tick();
    check("t2_producer", io.out_entry, p);
    io.in_valid = 1'b0;
    tick();
    check("t2_consumer_held", W'(io.out_valid), '0);
    tick();
    wb_valid = 1'b1; wb_reg = 6'd10;
    tick();
    wb_valid = 1'b0;
    check("t2_wb_edge", W'(io.out_valid), '0);
    tick();
    check("t2_consumer_valid", W'(io.out_valid), W'(1));
    check("t2_consumer_entry", io.out_entry, c);
    flush_cycle();

    // Older entry blocked, younger bypasses it.
    x = mk(12, 1, 2, 1'b1, 'h31);
    o = mk(13, 12, 0, 1'b1, 'h32);
    y = mk(14, 6, 7, 1'b1, 'h33);
    io.in_valid = 1'b1; io.in_entry = x;
    tick();
    io.in_entry = o;
    tick();
    io.in_entry = y;
    tick();
    check("t3_none_ready", W'(io.out_valid), '0);
    io.in_valid = 1'b0;
    tick();
    check("t3_younger_first", io.out_entry, y);
    tick();
    wb_valid = 1'b1; wb_reg = 6'd12;
    tick();
    wb_valid = 1'b0;
    tick();
    check("t3_older_after_wb", io.out_entry, o);
    flush_cycle();

    // Full window of blocked entries.
    p = mk(20, 1, 2, 1'b1, 'h40);
    io.in_valid = 1'b1; io.in_entry = p;
    tick();
    for (int k = 0; k < 8; k++) begin
      blk[k] = mk(21 + k, 20, 0, 1'b1, 'h41 + k);
      io.in_entry = blk[k];
      tick();
    end
    check("t4_full_ready", W'(io.in_ready), '0);
    check("t4_full_occ", W'(occupancy), W'(8));
    io.in_entry = mk(40, 1, 2, 1'b0, 'h4F);
    tick();
    check("t4_ninth_refused", W'(occupancy), W'(8));
    wb_valid = 1'b1; wb_reg = 6'd20;
    tick();
    wb_valid = 1'b0; io.in_valid = 1'b0;
    check("t4_still_full", W'(io.in_ready), '0);
    tick();
    check("t4_oldest_issues", io.out_entry, blk[0]);
    check("t4_ready_back", W'(io.in_ready), W'(1));
    check("t4_occ_7", W'(occupancy), W'(7));
    for (int k = 0; k < 8; k++) tick();
    flush_cycle();

    // FREEZE holds the registered request.
    a  = mk(42, 1, 2, 1'b1, 'h51);
    b  = mk(43, 3, 4, 1'b1, 'h52);
    cc = mk(44, 5, 6, 1'b1, 'h53);
    io.in_valid = 1'b1; io.in_entry = a;
    tick();
    io.in_entry = b;
    tick();
    check("t5_first", io.out_entry, a);
    FREEZE = 1'b1; io.in_entry = cc;
    tick();
    io.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("t5_hold_entry", io.out_entry, a);
      check("t5_hold_occ", W'(occupancy), W'(2));
      tick();
    end
    check("t5_hold_valid", W'(io.out_valid), W'(1));
    FREEZE = 1'b0;
    tick();
    check("t5_release_b", io.out_entry, b);
    tick();
    check("t5_then_c", io.out_entry, cc);
    flush_cycle();

    // Mispredict overrides FREEZE.
    p = mk(30, 1, 2, 1'b1, 'h60);
    io.in_valid = 1'b1; io.in_entry = p;
    tick();
    io.in_entry = mk(31, 30, 0, 1'b1, 'h61);
    tick();
    check("t6_producer", io.out_entry, p);
    FREEZE = 1'b1;
    for (int k = 1; k < 5; k++) begin
      io.in_entry = mk(31 + k, 30, 0, 1'b1, 'h61 + k);
      tick();
    end
    io.in_valid = 1'b0;
    check("t6_occ5", W'(occupancy), W'(5));
    mispredict = 1'b1;
    tick();
    mispredict = 1'b0;
    check("t6_occ0", W'(occupancy), '0);
    check("t6_out_valid", W'(io.out_valid), '0);
    check("t6_out_entry", io.out_entry, '0);
    check("t6_in_ready", W'(io.in_ready), W'(1));
    FREEZE = 1'b0;
    x = mk(36, 30, 0, 1'b1, 'h66);
    io.in_valid = 1'b1; io.in_entry = x;
    tick();
    io.in_valid = 1'b0;
    tick();
    check("t6_busy_cleared", io.out_entry, x);

    // Reset mid-operation drops window contents and the in-flight enqueue.
    io.in_valid = 1'b1; io.in_entry = mk(37, 36, 0, 1'b1, 'h71);
    tick();
    RESET = 1'b1; io.in_entry = mk(38, 1, 2, 1'b1, 'h72);
    tick();
    RESET = 1'b0; io.in_valid = 1'b0;
    check("t7_occ0", W'(occupancy), '0);
    check("t7_out_valid", W'(io.out_valid), '0);
    tick();
    check("t7_no_ghost", W'(io.out_valid), '0);

    // Same-cycle wakeup and set of one register: set wins; link entries need no sources.
    wb_valid = 1'b1; wb_reg = 6'd45;
    io.in_valid = 1'b1; io.in_entry = mk(45, 1, 2, 1'b1, 'h81);
    tick();
    wb_valid = 1'b0;
    io.in_entry = mk(46, 45, 0, 1'b1, 'h82);
    tick();
    io.in_valid = 1'b0;
    tick();
    check("t8_set_wins", W'(io.out_valid), '0);
    lk = mk(47, 45, 45, 1'b1, 'h83, 1'b1);
    io.in_valid = 1'b1; io.in_entry = lk;
    tick();
    io.in_valid = 1'b0;
    tick();
    check("t8_link_ready", io.out_entry, lk);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
